// File: rtl/phold_pkg.sv
// Shared definitions for the PHOLD logical-process core: FSM encoding,
// default widths and random-field layout, and a saturating timestamp adder.
package phold_pkg;

    localparam int unsigned PKG_TW      = 16;
    localparam int unsigned PKG_MIN_GAP = 10;
    localparam int unsigned PKG_NIDB    = 3;
    localparam int unsigned PKG_NRB     = 12;
    localparam int unsigned PKG_OFFB    = 5;
    localparam int unsigned PKG_DLYB    = 3;
    localparam int unsigned PKG_FOB     = 2;
    localparam int unsigned PKG_CNTW    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StWork,
        StEmit,
        StWait
    } state_e;

    // Add at PKG_TW+1 bits and clamp to all-ones on overflow.
    function automatic logic [PKG_TW-1:0] sat_add(input logic [PKG_TW-1:0] a,
                                                  input logic [PKG_TW-1:0] b);
        logic [PKG_TW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PKG_TW] ? {PKG_TW{1'b1}} : sum[PKG_TW-1:0];
    endfunction

endpackage

// File: rtl/phold_ts_gen.sv
// Combinational saturating timestamp generator:
// new_time = sat(local_time + MIN_GAP + offset).
module phold_ts_gen #(
    parameter int unsigned TW      = 16,
    parameter int unsigned OFFB    = 5,
    parameter int unsigned MIN_GAP = 10
) (
    input  logic [TW-1:0]   local_time,
    input  logic [OFFB-1:0] offset,
    output logic [TW-1:0]   new_time
);

    localparam logic [TW:0] GAP = (TW+1)'(MIN_GAP);

    logic [TW:0] sum;

    // Widen by one bit so the carry-out flags overflow for the clamp.
    always_comb begin
        sum      = {1'b0, local_time} + GAP + {{(TW+1-OFFB){1'b0}}, offset};
        new_time = sum[TW] ? {TW{1'b1}} : sum[TW-1:0];
    end

endmodule

// File: rtl/phold_core_mc.sv
// PHOLD logical-process core: accepts one event, waits a random processing
// delay, then emits 1..2**FOB new events, each held until acknowledged.
// Flags causality violations (event older than GVT) and counts completed events.
module phold_core_mc
    import phold_pkg::*;
#(
    parameter int unsigned NIDB    = PKG_NIDB,
    parameter int unsigned NRB     = PKG_NRB,
    parameter int unsigned TW      = PKG_TW,
    parameter int unsigned MIN_GAP = PKG_MIN_GAP,
    parameter int unsigned OFFB    = PKG_OFFB,
    parameter int unsigned DLYB    = PKG_DLYB,
    parameter int unsigned FOB     = PKG_FOB,
    parameter int unsigned CNTW    = PKG_CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            event_valid,
    input  logic [NIDB-1:0] event_id,
    input  logic [TW-1:0]   event_time,
    input  logic [TW-1:0]   global_time,
    input  logic [NRB-1:0]  random_in,
    output logic            ready,
    output logic [TW-1:0]   new_event_time,
    output logic [NIDB-1:0] new_event_target,
    output logic            new_event_ready,
    input  logic            ack,
    output logic            causality_err,
    output logic [CNTW-1:0] events_done
);

    state_e          state_q;
    logic [TW-1:0]   local_time_q;
    logic [DLYB-1:0] delay_q;
    logic [DLYB-1:0] dly_cnt_q;
    logic [FOB:0]    remaining_q;
    logic [TW-1:0]   ts_next;

    // The incoming id does not influence generated events; GVT is compared
    // directly in the accept cycle, so neither needs a holding register.
    logic unused_in;
    assign unused_in = ^{event_id, random_in};

    assign ready = (state_q == StIdle);

    phold_ts_gen #(
        .TW      (TW),
        .OFFB    (OFFB),
        .MIN_GAP (MIN_GAP)
    ) u_ts_gen (
        .local_time (local_time_q),
        .offset     (random_in[OFFB-1:0]),
        .new_time   (ts_next)
    );

    // Event FSM with registered outputs and bookkeeping counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            local_time_q     <= '0;
            delay_q          <= '0;
            dly_cnt_q        <= '0;
            remaining_q      <= '0;
            new_event_time   <= '0;
            new_event_target <= '0;
            new_event_ready  <= 1'b0;
            causality_err    <= 1'b0;
            events_done      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (event_valid) begin
                        if (event_time < global_time) begin
                            causality_err <= 1'b1;
                        end else begin
                            local_time_q <= event_time;
                            delay_q      <= random_in[DLYB-1:0];
                            remaining_q  <= {1'b0, random_in[DLYB+FOB-1:DLYB]} + (FOB+1)'(1);
                            dly_cnt_q    <= '0;
                            state_q      <= StWork;
                        end
                    end
                end
                StWork: begin
                    if (dly_cnt_q == delay_q) begin
                        state_q <= StEmit;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + DLYB'(1);
                    end
                end
                StEmit: begin
                    new_event_time   <= ts_next;
                    new_event_target <= random_in[NRB-1 -: NIDB];
                    new_event_ready  <= 1'b1;
                    state_q          <= StWait;
                end
                StWait: begin
                    if (ack) begin
                        new_event_ready <= 1'b0;
                        remaining_q     <= remaining_q - (FOB+1)'(1);
                        if (remaining_q == (FOB+1)'(1)) begin
                            events_done <= events_done + CNTW'(1);
                            state_q     <= StIdle;
                        end else begin
                            state_q <= StEmit;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_phold_core_mc.sv
// Self-checking bench for phold_core_mc (default parameters).
module tb_phold_core_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        event_valid;
    logic [2:0]  event_id;
    logic [15:0] event_time;
    logic [15:0] global_time;
    logic [11:0] random_in;
    logic        ready;
    logic [15:0] new_event_time;
    logic [2:0]  new_event_target;
    logic        new_event_ready;
    logic        ack;
    logic        causality_err;
    logic [15:0] events_done;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          rnd_auto    = 1'b0;
    logic [11:0] last_rnd;
    int          exp_done    = 0;
    bit          exp_err     = 1'b0;

    phold_core_mc dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .event_valid      (event_valid),
        .event_id         (event_id),
        .event_time       (event_time),
        .global_time      (global_time),
        .random_in        (random_in),
        .ready            (ready),
        .new_event_time   (new_event_time),
        .new_event_target (new_event_target),
        .new_event_ready  (new_event_ready),
        .ack              (ack),
        .causality_err    (causality_err),
        .events_done      (events_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] et;
        logic [15:0] gvt;
        logic [11:0] rnd_acc;
        logic [11:0] rnd_emit;
        bit          err;
        logic [15:0] exp_time;
        logic [2:0]  exp_tgt;
        int          exp_lat;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remembers the random value present at the edge, then samples 1 time unit after it.
    task automatic tick();
        last_rnd = random_in;
        @(posedge clk);
        #1;
        if (rnd_auto) random_in = 12'($urandom);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!new_event_ready && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;
        logic [11:0] acc_rnd;
        int d;
        int f;

        tbl[0] = '{16'd100,   16'd50,    12'h000, 12'h007, 1'b0, 16'd117,   3'd0, 3};
        tbl[1] = '{16'hFFF0,  16'd0,     12'h005, 12'hE1F, 1'b0, 16'hFFFF,  3'd7, 8};
        tbl[2] = '{16'hFFF5,  16'hFFF5,  12'h002, 12'h200, 1'b0, 16'hFFFF,  3'd1, 5};
        tbl[3] = '{16'hFFF6,  16'd0,     12'h001, 12'h000, 1'b0, 16'hFFFF,  3'd0, 4};
        tbl[4] = '{16'd1000,  16'd999,   12'h007, 12'h5A3, 1'b0, 16'd1013,  3'd2, 10};
        tbl[5] = '{16'd40,    16'd50,    12'h000, 12'h000, 1'b1, 16'd0,     3'd0, 0};

        rst_n = 1'b0; event_valid = 1'b0; event_id = 3'd0; event_time = '0;
        global_time = '0; random_in = '0; ack = 1'b0;
        #23;
        check("rst_ready", ready, 1);
        check("rst_ner", new_event_ready, 0);
        check("rst_time", new_event_time, 0);
        check("rst_tgt", new_event_target, 0);
        check("rst_err", causality_err, 0);
        check("rst_done", events_done, 0);
        rst_n = 1'b1;
        tick();

        // Reset pulse while a generated event is waiting for its ack.
        event_time = 16'd100; global_time = 16'd0; random_in = 12'h018; event_valid = 1'b1;
        tick();
        event_valid = 1'b0;
        wait_ready(n);
        check("midrst_pre_ner", new_event_ready, 1);
        rst_n = 1'b0;
        #2;
        check("midrst_ner", new_event_ready, 0);
        check("midrst_ready", ready, 1);
        check("midrst_done", events_done, 0);
        check("midrst_time", new_event_time, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_ready2", ready, 1);
        check("midrst_ner2", new_event_ready, 0);

        // Table: single-fanout events plus a causality violation.
        for (int i = 0; i < 6; i++) begin
            event_time = tbl[i].et; global_time = tbl[i].gvt;
            event_id = 3'(i); random_in = tbl[i].rnd_acc; event_valid = 1'b1;
            tick();
            event_valid = 1'b0;
            random_in = tbl[i].rnd_emit;
            if (tbl[i].err) begin
                exp_err = 1'b1;
                check("tbl_err", causality_err, 1);
                check("tbl_err_ready", ready, 1);
                tick(); tick(); tick();
                check("tbl_err_noout", new_event_ready, 0);
                check("tbl_err_ready2", ready, 1);
                check("tbl_err_done", events_done, 32'(exp_done));
            end else begin
                wait_ready(n);
                check("tbl_latency", n + 1, tbl[i].exp_lat);
                check("tbl_time", new_event_time, tbl[i].exp_time);
                check("tbl_target", new_event_target, tbl[i].exp_tgt);
                check("tbl_busy", ready, 0);
                ack = 1'b1;
                tick();
                ack = 1'b0;
                exp_done++;
                check("tbl_ner_drop", new_event_ready, 0);
                check("tbl_ready", ready, 1);
                check("tbl_done", events_done, 32'(exp_done));
            end
        end

        // Fan-out of 4 with a long ack hold and ignored input traffic.
        event_time = 16'd500; global_time = 16'd0; random_in = 12'h01B; event_valid = 1'b1;
        tick();
        event_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            random_in = 12'(k * 512 + k * 3);
            wait_ready(n);
            check("fan_latency", n, (k == 0) ? 5 : 1);
            check("fan_time", new_event_time, 32'(510 + 3 * k));
            check("fan_target", new_event_target, 32'(k));
            random_in = 12'hFFF; event_valid = 1'b1; event_time = 16'd7;
            repeat (5) begin
                tick();
                check("fan_hold_ner", new_event_ready, 1);
                check("fan_hold_time", new_event_time, 32'(510 + 3 * k));
                check("fan_hold_tgt", new_event_target, 32'(k));
                check("fan_hold_ready", ready, 0);
            end
            event_valid = 1'b0;
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check("fan_ner_drop", new_event_ready, 0);
        end
        exp_done++;
        check("fan_ready", ready, 1);
        check("fan_done", events_done, 32'(exp_done));
        tick(); tick();
        check("fan_no_fifth", new_event_ready, 0);

        // Randomised events against a transaction-level model.
        rnd_auto = 1'b1;
        for (int e = 0; e < 40; e++) begin
            bit viol;
            viol = ($urandom_range(0, 7) == 0);
            if (viol) begin
                event_time = 16'($urandom_range(0, 65435));
                global_time = event_time + 16'($urandom_range(1, 100));
            end else begin
                event_time = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(65490, 65535))
                                                           : 16'($urandom_range(0, 65535));
                global_time = 16'($urandom_range(0, 32'(event_time)));
            end
            event_valid = 1'b1;
            tick();
            event_valid = 1'b0;
            acc_rnd = last_rnd;
            if (viol) begin
                exp_err = 1'b1;
                check("rnd_err", causality_err, 32'(exp_err));
                check("rnd_err_ready", ready, 1);
                continue;
            end
            check("rnd_err_keep", causality_err, 32'(exp_err));
            check("rnd_busy", ready, 0);
            d = int'(acc_rnd[2:0]);
            f = int'(acc_rnd[4:3]);
            for (int k = 0; k <= f; k++) begin
                wait_ready(n);
                check("rnd_latency", n, (k == 0) ? d + 2 : 1);
                t = int'(event_time) + 10 + int'(last_rnd[4:0]);
                if (t > 65535) t = 65535;
                check("rnd_time", new_event_time, 32'(t));
                check("rnd_target", new_event_target, 32'(last_rnd[11:9]));
                repeat ($urandom_range(0, 3)) tick();
                check("rnd_hold_time", new_event_time, 32'(t));
                check("rnd_hold_ner", new_event_ready, 1);
                ack = 1'b1;
                tick();
                ack = 1'b0;
                check("rnd_ner_drop", new_event_ready, 0);
            end
            exp_done++;
            check("rnd_ready", ready, 1);
            check("rnd_done", events_done, 32'(exp_done));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
